// File: rtl/pipelined_dr_alm.sv
// rtl/pipelined_dr_alm.sv - three-stage streaming signed DR-ALM multiplier with per-transaction LSB policy
// Optional result counters are built when DR_ALM_PERF_CNT_EN is defined.
module pipelined_dr_alm #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_z,
  output logic [31:0]          o_txn_cnt,
  output logic [31:0]          o_zero_cnt
);

  localparam int W  = WIDTH;
  localparam int T  = KEEP_WIDTH;
  localparam int LW = $clog2(W);
  localparam int KW = $clog2(W) + 1;
  localparam int ZW = 2 * W;

  localparam logic [W-1:0]  REM_MASK = W'((64'd1 << (W - T)) - 64'd1);
  localparam logic [W-1:0]  REM_HALF = W'(64'd1 << (W - T - 1));
  localparam logic [KW-1:0] T_K      = KW'(T);
  localparam logic [LW-1:0] TOP_IDX  = LW'(W - 1);

  function automatic logic [LW-1:0] lead_one(input logic [W-1:0] v);
    lead_one = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) lead_one = LW'(i);
    end
  endfunction

  // Kept significand: t-1 fraction bits below the leading one, plus the policy LSB.
  function automatic logic [T-1:0] sig_x(input logic [W-1:0] mag, input logic [LW-1:0] k,
                                         input logic [1:0] mode);
    logic [W-1:0] norm;
    logic         lsb;
    norm = mag << (TOP_IDX - k);
    case (mode)
      2'b01:   lsb = (norm & REM_MASK) > REM_HALF;
      2'b10:   lsb = 1'b0;
      default: lsb = 1'b1;
    endcase
    return {norm[W-2 -: T-1], lsb};
  endfunction

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic          sign1_q, sign1_d, zero1_q, zero1_d;
  logic [W-1:0]  abs_a1_q, abs_a1_d, abs_b1_q, abs_b1_d;
  logic [LW-1:0] ka1_q, ka1_d, kb1_q, kb1_d;
  logic [1:0]    mode1_q, mode1_d;
  logic          sign2_q, sign2_d, zero2_q, zero2_d;
  logic [T-1:0]  sum2_q, sum2_d;
  logic [KW-1:0] k2_q, k2_d;
  logic [ZW-1:0] z3_q, z3_d;

  logic          ld1, ld2, ld3, en1, en2, en3;
  logic [W-1:0]  abs_a, abs_b;
  logic [T:0]    sum_x;
  logic [ZW-1:0] mant, mag;

  // A slot accepts when it is empty or its occupant moves on this cycle.
  assign ld3     = !v3_q | i_ready;
  assign ld2     = !v2_q | ld3;
  assign ld1     = !v1_q | ld2;
  assign en1     = i_valid & ld1;
  assign en2     = v1_q & ld2;
  assign en3     = v2_q & ld3;
  assign o_ready = ld1;
  assign o_valid = v3_q;
  assign o_z     = z3_q;

  assign abs_a = i_a[W-1] ? (~i_a + 1'b1) : i_a;
  assign abs_b = i_b[W-1] ? (~i_b + 1'b1) : i_b;
  assign sum_x = {1'b0, sig_x(abs_a1_q, ka1_q, mode1_q)} +
                 {1'b0, sig_x(abs_b1_q, kb1_q, mode1_q)} + (T+1)'(1);
  assign mant  = ZW'({1'b1, sum2_q});
  assign mag   = (k2_q >= T_K) ? (mant << (k2_q - T_K)) : (mant >> (T_K - k2_q));

  always_comb begin
    v1_d     = ld1 ? i_valid : v1_q;
    v2_d     = ld2 ? v1_q : v2_q;
    v3_d     = ld3 ? v2_q : v3_q;
    sign1_d  = sign1_q;
    zero1_d  = zero1_q;
    abs_a1_d = abs_a1_q;
    abs_b1_d = abs_b1_q;
    ka1_d    = ka1_q;
    kb1_d    = kb1_q;
    mode1_d  = mode1_q;
    sign2_d  = sign2_q;
    zero2_d  = zero2_q;
    sum2_d   = sum2_q;
    k2_d     = k2_q;
    z3_d     = z3_q;
    if (en1) begin
      sign1_d  = i_a[W-1] ^ i_b[W-1];
      zero1_d  = (i_a == '0) | (i_b == '0);
      abs_a1_d = abs_a;
      abs_b1_d = abs_b;
      ka1_d    = lead_one(abs_a);
      kb1_d    = lead_one(abs_b);
      mode1_d  = i_mode;
    end
    if (en2) begin
      sign2_d = sign1_q;
      zero2_d = zero1_q;
      sum2_d  = sum_x[T-1:0];
      k2_d    = KW'(ka1_q) + KW'(kb1_q) + KW'(sum_x[T]);
    end
    if (en3) begin
      z3_d = zero2_q ? '0 : (sign2_q ? -mag : mag);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sign1_q  <= 1'b0;
      zero1_q  <= 1'b0;
      abs_a1_q <= '0;
      abs_b1_q <= '0;
      ka1_q    <= '0;
      kb1_q    <= '0;
      mode1_q  <= '0;
      sign2_q  <= 1'b0;
      zero2_q  <= 1'b0;
      sum2_q   <= '0;
      k2_q     <= '0;
      z3_q     <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sign1_q  <= sign1_d;
      zero1_q  <= zero1_d;
      abs_a1_q <= abs_a1_d;
      abs_b1_q <= abs_b1_d;
      ka1_q    <= ka1_d;
      kb1_q    <= kb1_d;
      mode1_q  <= mode1_d;
      sign2_q  <= sign2_d;
      zero2_q  <= zero2_d;
      sum2_q   <= sum2_d;
      k2_q     <= k2_d;
      z3_q     <= z3_d;
    end
  end

`ifdef DR_ALM_PERF_CNT_EN
  logic        zero3_q, zero3_d;
  logic [31:0] txn_q, txn_d, zc_q, zc_d;

  always_comb begin
    zero3_d = en3 ? zero2_q : zero3_q;
    txn_d   = txn_q;
    zc_d    = zc_q;
    if (v3_q & i_ready) begin
      txn_d = txn_q + 32'd1;
      if (zero3_q) zc_d = zc_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero3_q <= 1'b0;
      txn_q   <= '0;
      zc_q    <= '0;
    end else begin
      zero3_q <= zero3_d;
      txn_q   <= txn_d;
      zc_q    <= zc_d;
    end
  end

  assign o_txn_cnt  = txn_q;
  assign o_zero_cnt = zc_q;
`else
  assign o_txn_cnt  = '0;
  assign o_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_pipelined_dr_alm.sv
// tb/tb_pipelined_dr_alm.sv - self-checking bench for pipelined_dr_alm (WIDTH=16, KEEP_WIDTH=5)
module tb_pipelined_dr_alm;

  localparam int T = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [15:0] i_a, i_b;
  logic [1:0]  i_mode;
  logic [31:0] o_z, o_txn_cnt, o_zero_cnt;

  pipelined_dr_alm #(.WIDTH(16), .KEEP_WIDTH(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_z(o_z), .o_txn_cnt(o_txn_cnt), .o_zero_cnt(o_zero_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    bit          zero;
  } exp_t;

  vec_t        vecs[16];
  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          n_zero = 0;
  logic [31:0] cur_exp = '0;
  bit          cur_zero = 1'b0;
  bit          rnd_rdy = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] held_z = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: floor-log2 exponent, t-1 fraction bits, remainder compared to half an ulp.
  function automatic void op_x(input longint mag, input logic [1:0] m, output int k, output longint x);
    longint r, scaled, frac, rem;
    bit     up, lsb;
    k = 0;
    while ((longint'(1) << (k + 1)) <= mag) k++;
    r      = mag - (longint'(1) << k);
    scaled = r << (T - 1);
    frac   = scaled >> k;
    rem    = scaled - (frac << k);
    up     = (2 * rem) > (longint'(1) << k);
    case (m)
      2'd1:    lsb = up;
      2'd2:    lsb = 1'b0;
      default: lsb = 1'b1;
    endcase
    x = frac * 2 + longint'(lsb);
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    exp_t   r;
    longint ma, mb, xa, xb, sum, mant, mag;
    int     ka, kb, kk;
    r.zero = (a == 0) || (b == 0);
    r.z    = '0;
    if (r.zero) return r;
    ma = longint'($signed(a));
    mb = longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    op_x(ma, m, ka, xa);
    op_x(mb, m, kb, xb);
    sum  = xa + xb + 1;
    kk   = ka + kb + ((sum >= (longint'(1) << T)) ? 1 : 0);
    mant = (longint'(1) << T) + (sum % (longint'(1) << T));
    mag  = (kk >= T) ? (mant << (kk - T)) : (mant >> (T - kk));
    r.z  = 32'((a[15] ^ b[15]) ? -mag : mag);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: inputs and outputs are stable at the falling edge, so transfers are predicted here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      hold_pend = 1'b0;
      n_pop = 0;
      n_zero = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_z", o_z, held_z);
      end
      hold_pend = o_valid && !i_ready;
      held_z = o_z;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", o_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", o_z, e.z);
          n_pop++;
          if (e.zero) n_zero++;
        end
        pop_cyc.push_back(cyc);
      end
      if (i_valid && o_ready) begin
        e.z = cur_exp;
        e.zero = cur_zero;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                      input logic [31:0] e);
    int n;
    i_a = a;
    i_b = b;
    i_mode = m;
    cur_exp = e;
    cur_zero = (a == 0) || (b == 0);
    i_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (o_ready || n >= 200) break;
      tick();
      n++;
    end
    chk("accept", o_ready, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    exp_t r;
    r = model(a, b, m);
    send(a, b, m, r.z);
  endtask

  task automatic drain();
    int n;
    i_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h0001;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  consec;
    vecs[0]  = '{16'd3,     16'd5,     2'd0, 32'h0000000E};
    vecs[1]  = '{16'd3,     16'd5,     2'd1, 32'h0000000E};
    vecs[2]  = '{16'hFFFD,  16'd5,     2'd0, 32'hFFFFFFF2};
    vecs[3]  = '{16'd0,     16'd1234,  2'd0, 32'h00000000};
    vecs[4]  = '{16'h8000,  16'h8000,  2'd0, 32'h46000000};
    vecs[5]  = '{16'h8000,  16'h8000,  2'd3, 32'h46000000};
    vecs[6]  = '{16'd1,     16'd1,     2'd0, 32'h00000001};
    vecs[7]  = '{16'd1,     16'd1,     2'd2, 32'h00000001};
    vecs[8]  = '{16'hFFFF,  16'hFFFF,  2'd0, 32'h00000001};
    vecs[9]  = '{16'd7,     16'd7,     2'd0, 32'd51};
    vecs[10] = '{16'd7,     16'd7,     2'd1, 32'd49};
    vecs[11] = '{16'd71,    16'd1,     2'd1, 32'd72};
    vecs[12] = '{16'd70,    16'd1,     2'd1, 32'd70};
    vecs[13] = '{16'd71,    16'd1,     2'd2, 32'd70};
    vecs[14] = '{16'd71,    16'd1,     2'd0, 32'd74};
    vecs[15] = '{16'd5,     16'hFFFD,  2'd2, 32'hFFFFFFF2};

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a = '0;
    i_b = '0;
    i_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_z", o_z, 0);
    chk("reset_o_ready", o_ready, 1);
    chk("reset_txn_cnt", o_txn_cnt, 0);
    chk("reset_zero_cnt", o_zero_cnt, 0);
    tick();

    // Latency: result visible on the third falling edge after the accepting one.
    i_a = 16'd3;
    i_b = 16'd5;
    i_mode = 2'd0;
    cur_exp = 32'h0000000E;
    cur_zero = 1'b0;
    i_valid = 1'b1;
    @(negedge clk);
    chk("latency_accept", o_ready, 1);
    tick();
    i_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (o_valid) break;
    end
    chk("latency_cycles", n, 3);
    drain();

    pop_cyc.delete();
    for (int i = 0; i < 16; i++) send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp);
    drain();
    consec = (pop_cyc.size() == 16);
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) consec = 1'b0;
    chk("throughput_back_to_back", consec, 1);

    // Stall: three fill the pipe, the fourth waits, then all drain in order.
    i_ready = 1'b0;
    send_model(16'd300, 16'hFF38, 2'd0);
    send_model(16'd12345, 16'd77, 2'd1);
    send_model(16'h9000, 16'd3, 2'd2);
    i_a = 16'd999;
    i_b = 16'd999;
    i_mode = 2'd1;
    i_valid = 1'b1;
    @(negedge clk);
    chk("stall_o_ready", o_ready, 0);
    chk("stall_o_valid", o_valid, 1);
    tick();
    @(negedge clk);
    chk("stall_o_ready_2", o_ready, 0);
    tick();
    i_ready = 1'b1;
    send_model(16'd999, 16'd999, 2'd1);
    drain();
    chk("stall_no_leftover", exp_q.size(), 0);

    // Reset with two in flight and a result stalled at the output.
    i_ready = 1'b0;
    send_model(16'd1000, 16'd1000, 2'd0);
    send_model(16'd42, 16'hFFF0, 2'd0);
    tick();
    chk("pre_reset_o_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_o_valid", o_valid, 0);
    chk("mid_reset_o_z", o_z, 0);
    chk("mid_reset_txn_cnt", o_txn_cnt, 0);
    chk("mid_reset_zero_cnt", o_zero_cnt, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_o_valid", o_valid, 0);
    chk("post_reset_o_ready", o_ready, 1);
    tick();
    send_model(16'd3, 16'hFFFB, 2'd0);
    send_model(16'd0, 16'd55, 2'd1);
    send_model(16'd123, 16'd456, 2'd2);
    send_model(16'h8000, 16'd0, 2'd0);
    send_model(16'd9, 16'd9, 2'd3);
    drain();
`ifdef DR_ALM_PERF_CNT_EN
    chk("txn_cnt_5", o_txn_cnt, 5);
    chk("zero_cnt_2", o_zero_cnt, 2);
`else
    chk("txn_cnt_tied", o_txn_cnt, 0);
    chk("zero_cnt_tied", o_zero_cnt, 0);
`endif

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_model(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)));
    end
    rnd_rdy = 1'b0;
    drain();
`ifdef DR_ALM_PERF_CNT_EN
    chk("final_txn_cnt", o_txn_cnt, n_pop);
    chk("final_zero_cnt", o_zero_cnt, n_zero);
`else
    chk("final_txn_cnt_tied", o_txn_cnt, 0);
    chk("final_zero_cnt_tied", o_zero_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
